// File: rtl/sys_bus_regbank_pkg.sv
// Shared constants and types for the system-bus register bank responder.
package sys_bus_regbank_pkg;

    localparam int unsigned DW = 32;

    // CTL register bit positions
    localparam int unsigned CTL_COMMIT = 0;
    localparam int unsigned CTL_AUTO   = 1;
    localparam int unsigned CTL_OVF    = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WACK = 2'd1;
    localparam logic [1:0] RD   = 2'd2;

    // Reset values for up to REG_RST_N RW registers (NR must not exceed this)
    localparam int unsigned REG_RST_N = 16;
    localparam logic [DW-1:0] REG_RST [REG_RST_N] = '{
        32'hC0DE_00FF, 32'hC0DE_01FE, 32'hC0DE_02FD, 32'hC0DE_03FC,
        32'hC0DE_04FB, 32'hC0DE_05FA, 32'hC0DE_06F9, 32'hC0DE_07F8,
        32'hC0DE_08F7, 32'hC0DE_09F6, 32'hC0DE_0AF5, 32'hC0DE_0BF4,
        32'hC0DE_0CF3, 32'hC0DE_0DF2, 32'hC0DE_0EF1, 32'hC0DE_0FF0
    };

    typedef enum logic [1:0] {
        DEC_RW,
        DEC_STS,
        DEC_CTL,
        DEC_NONE
    } dec_e;

    typedef struct packed {
        logic          ack;
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/sys_bus_regbank_if.sv
// System bus slave-port signal bundle: request in, response out on the slave side.
interface sys_bus_if #(
    parameter int unsigned SW = 20
);
    logic [SW-1:0] addr;
    logic [31:0]   wdata;
    logic          wen;
    logic          ren;
    logic [31:0]   rdata;
    logic          err;
    logic          ack;

    modport m (output addr, wdata, wen, ren, input rdata, err, ack);
    modport s (input addr, wdata, wen, ren, output rdata, err, ack);
endinterface

// File: rtl/sys_bus_regbank_rd_pipe.sv
// RL-deep response delay line; the last stage is the registered bus response.
module sys_bus_rd_pipe
    import sys_bus_regbank_pkg::*;
#(
    parameter int unsigned RL = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic rd_vld,
    input  rsp_t rd_rsp,
    input  logic wr_vld,
    input  logic wr_err,
    output rsp_t rsp
);

    rsp_t [RL-1:0] stg_q;

    // Write acks bypass straight into the output stage; the FSM never overlaps them with reads.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stg_q <= '0;
        end else begin
            stg_q[0] <= rd_vld ? rd_rsp : '0;
            for (int i = 1; i < int'(RL); i++) begin
                stg_q[i] <= stg_q[i-1];
            end
            if (wr_vld) begin
                stg_q[RL-1].ack   <= 1'b1;
                stg_q[RL-1].err   <= wr_err;
                stg_q[RL-1].rdata <= '0;
            end
        end
    end

    assign rsp = stg_q[RL-1];

endmodule

// File: rtl/sys_bus_regbank.sv
// Register-bank responder: NR shadow/active RW registers, NS status words and a CTL word.
module sys_bus_regbank
    import sys_bus_regbank_pkg::*;
#(
    parameter int unsigned SW = 20,
    parameter int unsigned NR = 8,
    parameter int unsigned NS = 4,
    parameter int unsigned RL = 2
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    sys_bus_if.s                   bus,
    output logic [NR-1:0][DW-1:0]  reg_o,
    output logic [NR-1:0]          wr_o,
    input  logic [NS-1:0][DW-1:0]  sts_i,
    input  logic                   upd_i
);

    localparam int unsigned KW = SW - 2;
    localparam int unsigned CW = $clog2(RL + 1);
    localparam logic [KW-1:0] K_CTL = '1;

    logic [KW-1:0]         k;
    logic                  unused_addr_lsb;
    dec_e                  dec;
    logic                  dec_none;
    logic [DW-1:0]         rd_word;
    logic [NR-1:0][DW-1:0] shadow_q;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_acc, rd_acc, ovf_set;

    logic auto_q, ovf_q;
    logic ctl_wr, commit;

    rsp_t rd_rsp, rsp;

    assign k               = bus.addr[SW-1:2];
    assign unused_addr_lsb = ^bus.addr[1:0];

    // Address decode
    always_comb begin
        dec = DEC_NONE;
        if (k < KW'(NR)) begin
            dec = DEC_RW;
        end else if (k < KW'(NR + NS)) begin
            dec = DEC_STS;
        end else if (k == K_CTL) begin
            dec = DEC_CTL;
        end
    end

    assign dec_none = (dec == DEC_NONE);

    // Read word selection; unmapped reads return zero
    always_comb begin
        rd_word = '0;
        case (dec)
            DEC_RW: begin
                for (int i = 0; i < int'(NR); i++) begin
                    if (k == KW'(i)) rd_word = shadow_q[i];
                end
            end
            DEC_STS: begin
                for (int i = 0; i < int'(NS); i++) begin
                    if (k == KW'(NR + i)) rd_word = sts_i[i];
                end
            end
            DEC_CTL: begin
                rd_word[CTL_OVF]  = ovf_q;
                rd_word[CTL_AUTO] = auto_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes are only taken in IDLE; anything arriving elsewhere is an overflow
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_acc  = 1'b0;
        rd_acc  = 1'b0;
        ovf_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.wen) begin
                    wr_acc  = 1'b1;
                    ovf_set = bus.ren;
                    state_d = WACK;
                end else if (bus.ren) begin
                    rd_acc  = 1'b1;
                    cnt_d   = CW'(RL - 1);
                    state_d = RD;
                end
            end
            WACK: begin
                ovf_set = bus.wen | bus.ren;
                state_d = IDLE;
            end
            RD: begin
                ovf_set = bus.wen | bus.ren;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ctl_wr = wr_acc && (dec == DEC_CTL);
    assign commit = upd_i | (ctl_wr & bus.wdata[CTL_COMMIT]);

    // A same-cycle overflow event outranks a write-1-to-clear
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            auto_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (ctl_wr) auto_q <= bus.wdata[CTL_AUTO];
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ctl_wr && bus.wdata[CTL_OVF]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < int'(NR); i++) begin : g_reg
        logic          hit;
        logic [DW-1:0] shd_q, act_q;
        logic          wr_q;

        assign hit = wr_acc && (dec == DEC_RW) && (k == KW'(i));

        // Commit forwards a same-cycle shadow write into the active copy
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                shd_q <= REG_RST[i];
                act_q <= REG_RST[i];
                wr_q  <= 1'b0;
            end else begin
                wr_q <= hit;
                if (hit) shd_q <= bus.wdata;
                if (commit) begin
                    act_q <= hit ? bus.wdata : shd_q;
                end else if (hit && auto_q) begin
                    act_q <= bus.wdata;
                end
            end
        end

        assign shadow_q[i] = shd_q;
        assign reg_o[i]    = act_q;
        assign wr_o[i]     = wr_q;
    end

    assign rd_rsp.ack   = 1'b1;
    assign rd_rsp.err   = dec_none;
    assign rd_rsp.rdata = rd_word;

    sys_bus_rd_pipe #(
        .RL (RL)
    ) u_rd_pipe (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .rd_vld (rd_acc),
        .rd_rsp (rd_rsp),
        .wr_vld (wr_acc),
        .wr_err (dec_none),
        .rsp    (rsp)
    );

    assign bus.ack   = rsp.ack;
    assign bus.err   = rsp.err;
    assign bus.rdata = rsp.rdata;

endmodule

// File: tb/tb_sys_bus_regbank.sv
// Bench for sys_bus_regbank: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the register bank.
module tb_sys_bus_regbank;

    localparam int unsigned SW   = 20;
    localparam int unsigned NR   = 8;
    localparam int unsigned NS   = 4;
    localparam int unsigned RL   = 2;
    localparam int          KMAX = (1 << (SW - 2)) - 1;

    logic                  clk;
    logic                  rstn;
    logic [NR-1:0][31:0]   reg_o;
    logic [NR-1:0]         wr_o;
    logic [NS-1:0][31:0]   sts;
    logic                  upd;

    sys_bus_if #(.SW(SW)) bus ();

    sys_bus_regbank #(
        .SW (SW),
        .NR (NR),
        .NS (NS),
        .RL (RL)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus),
        .reg_o  (reg_o),
        .wr_o   (wr_o),
        .sts_i  (sts),
        .upd_i  (upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [31:0]   m_shd [NR];
    logic [31:0]   m_act [NR];
    bit            m_auto, m_ovf;
    int            m_busy, m_pend;
    logic [31:0]   m_pdata;
    bit            m_perr;
    bit            e_ack, e_err;
    logic [31:0]   e_rdata;
    logic [NR-1:0] e_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rst_val(input int i);
        return {16'hC0DE, 8'(i), 8'(255 - i)};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < int'(NR); i++) begin
            m_shd[i] = rst_val(i);
            m_act[i] = rst_val(i);
        end
        m_auto  = 1'b0;
        m_ovf   = 1'b0;
        m_busy  = 0;
        m_pend  = 0;
        m_pdata = '0;
        m_perr  = 1'b0;
        e_ack   = 1'b0;
        e_err   = 1'b0;
        e_rdata = '0;
        e_wr    = '0;
    endfunction

    // Advance the model by one clock edge using the inputs that edge sampled
    function automatic void model_step();
        int          k;
        bit          commit;
        logic [31:0] d;
        if (!rstn) begin
            model_reset();
            return;
        end
        k       = int'(bus.addr[SW-1:2]);
        commit  = upd;
        e_ack   = 1'b0;
        e_err   = 1'b0;
        e_rdata = '0;
        e_wr    = '0;
        if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin
                e_ack   = 1'b1;
                e_err   = m_perr;
                e_rdata = m_pdata;
            end
        end
        if (m_busy > 0) begin
            if (bus.wen || bus.ren) m_ovf = 1'b1;
            m_busy--;
        end else if (bus.wen) begin
            e_ack = 1'b1;
            if (k < int'(NR)) begin
                m_shd[k] = bus.wdata;
                e_wr[k]  = 1'b1;
                if (m_auto) m_act[k] = bus.wdata;
            end else if (k < int'(NR + NS)) begin
                e_err = 1'b0;
            end else if (k == KMAX) begin
                m_auto = bus.wdata[1];
                if (bus.wdata[8]) m_ovf = 1'b0;
                if (bus.wdata[0]) commit = 1'b1;
            end else begin
                e_err = 1'b1;
            end
            if (bus.ren) m_ovf = 1'b1;
            m_busy = 1;
        end else if (bus.ren) begin
            m_perr = 1'b0;
            if (k < int'(NR))               d = m_shd[k];
            else if (k < int'(NR + NS))     d = sts[k - int'(NR)];
            else if (k == KMAX)             d = {23'b0, m_ovf, 6'b0, m_auto, 1'b0};
            else begin d = '0; m_perr = 1'b1; end
            m_pdata = d;
            m_pend  = int'(RL) - 1;
            if (m_pend == 0) begin
                e_ack   = 1'b1;
                e_err   = m_perr;
                e_rdata = m_pdata;
            end
            m_busy = int'(RL);
        end
        if (commit) begin
            for (int i = 0; i < int'(NR); i++) m_act[i] = m_shd[i];
        end
    endfunction

    task automatic step_cycle(input bit wen, input bit ren, input int k,
                              input logic [31:0] wdata, input bit u);
        bus.wen   = wen;
        bus.ren   = ren;
        bus.addr  = SW'(k << 2) | SW'($urandom_range(0, 3));
        bus.wdata = wdata;
        upd       = u;
        for (int i = 0; i < int'(NS); i++) sts[i] = $urandom;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step_cycle(1'b0, 1'b0, 0, 32'h0, 1'b0);
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ack",   32'(bus.ack), 32'(e_ack));
            chk("err",   32'(bus.err), 32'(e_err));
            chk("rdata", bus.rdata,    e_rdata);
            chk("wr_o",  32'(wr_o),    32'(e_wr));
            for (int i = 0; i < int'(NR); i++) begin
                chk($sformatf("reg_o[%0d]", i), reg_o[i], m_act[i]);
            end
        end
    end

    initial begin
        int r, k;
        logic [31:0] wd;
        rstn      = 1'b0;
        bus.wen   = 1'b0;
        bus.ren   = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        upd       = 1'b0;
        sts       = '0;
        model_reset();
        chk_en = 1'b1;
        idle(2);
        chk("rst_ack",  32'(bus.ack), 32'd0);
        chk("rst_reg0", reg_o[0], 32'hC0DE_00FF);
        chk("rst_wr",   32'(wr_o), 32'd0);
        rstn = 1'b1;
        idle(1);

        // Read word 0 after reset
        step_cycle(1'b0, 1'b1, 0, 32'h0, 1'b0);
        idle(1);
        chk("rd0_ack",  32'(bus.ack), 32'd1);
        chk("rd0_err",  32'(bus.err), 32'd0);
        chk("rd0_data", bus.rdata, 32'hC0DE_00FF);
        idle(1);

        // Shadow write then external commit
        step_cycle(1'b1, 1'b0, 3, 32'hDEAD_BEEF, 1'b0);
        chk("w3_ack",  32'(bus.ack), 32'd1);
        chk("w3_wr",   32'(wr_o), 32'h8);
        chk("w3_reg",  reg_o[3], 32'hC0DE_03FC);
        idle(1);
        step_cycle(1'b0, 1'b0, 0, 32'h0, 1'b1);
        chk("upd_reg3", reg_o[3], 32'hDEAD_BEEF);

        // AUTO mode writes straight through
        step_cycle(1'b1, 1'b0, KMAX, 32'h2, 1'b0);
        idle(1);
        step_cycle(1'b1, 1'b0, 1, 32'h1234_5678, 1'b0);
        chk("auto_reg1", reg_o[1], 32'h1234_5678);
        idle(1);

        // Unmapped read and write
        step_cycle(1'b0, 1'b1, int'(NR + NS), 32'h0, 1'b0);
        idle(1);
        chk("unm_rd_ack",  32'(bus.ack), 32'd1);
        chk("unm_rd_err",  32'(bus.err), 32'd1);
        chk("unm_rd_data", bus.rdata, 32'd0);
        idle(1);
        step_cycle(1'b1, 1'b0, int'(NR + NS), 32'h5555_AAAA, 1'b0);
        chk("unm_wr_ack", 32'(bus.ack), 32'd1);
        chk("unm_wr_err", 32'(bus.err), 32'd1);
        idle(1);

        // Back-to-back reads: second strobe dropped, OVF set
        step_cycle(1'b0, 1'b1, 0, 32'h0, 1'b0);
        step_cycle(1'b0, 1'b1, 0, 32'h0, 1'b0);
        chk("b2b_ack1", 32'(bus.ack), 32'd1);
        idle(1);
        chk("b2b_ack2", 32'(bus.ack), 32'd0);
        step_cycle(1'b0, 1'b1, KMAX, 32'h0, 1'b0);
        idle(1);
        chk("ctl_ovf", bus.rdata, 32'h102);
        idle(1);
        step_cycle(1'b1, 1'b0, KMAX, 32'h100, 1'b0);
        idle(1);
        step_cycle(1'b0, 1'b1, KMAX, 32'h0, 1'b0);
        idle(1);
        chk("ctl_clr", bus.rdata, 32'h0);
        idle(1);

        // Write and commit in the same cycle
        step_cycle(1'b1, 1'b0, 2, 32'hCAFE_0002, 1'b1);
        chk("wr_upd_reg2", reg_o[2], 32'hCAFE_0002);
        idle(1);

        // Reset during a pending read
        step_cycle(1'b0, 1'b1, 0, 32'h0, 1'b0);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_ack",   32'(bus.ack), 32'd0);
        chk("mid_rst_rdata", bus.rdata, 32'd0);
        chk("mid_rst_reg3",  reg_o[3], 32'hC0DE_03FC);
        idle(2);
        rstn = 1'b1;
        idle(1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5)       k = $urandom_range(0, NR - 1);
            else if (r < 7)  k = $urandom_range(NR, NR + NS - 1);
            else if (r == 7) k = KMAX;
            else             k = $urandom_range(NR + NS, KMAX - 1);
            wd = (k == KMAX) ? ($urandom & 32'h103) : $urandom;
            step_cycle($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25,
                       k, wd, $urandom_range(0, 15) == 0);
        end
        idle(4);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
